// File: rtl/lcd_dual_rd_sched.sv
// Per-frame read scheduler: flushes both camera FIFOs at frame start, then reads the
// left half of each line from cam0 and the right half from cam1 into one pixel stream.
module lcd_dual_rd_sched #(
  parameter int                DATA_W       = 16,
  parameter int                FLUSH_CYCLES = 16,
  parameter logic [DATA_W-1:0] BLANK_COLOR  = '0
) (
  input  logic              lcd_clk,
  input  logic              sys_rst_n,
  input  logic [10:0]       h_disp,
  input  logic [10:0]       v_disp,
  input  logic              frame_start,
  input  logic              data_req,
  input  logic [10:0]       pixel_xpos,
  input  logic [DATA_W-1:0] cam0_rd_data,
  input  logic              cam0_rd_empty,
  input  logic [DATA_W-1:0] cam1_rd_data,
  input  logic              cam1_rd_empty,
  input  logic              err_clr,
  output logic              rd_load,
  output logic              cam0_rd_en,
  output logic              cam1_rd_en,
  output logic [DATA_W-1:0] pixel_data,
  output logic              busy,
  output logic              underflow_err,
  output logic              resync_err,
  output logic [7:0]        frame_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_ACTIVE} state_t;

  localparam logic [7:0] FLUSH_LAST = 8'(FLUSH_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_flush_cnt;
  logic [10:0] r_line_cnt;
  logic [7:0]  r_frame_cnt;
  logic        r_req_q;
  logic        r_rd_q;
  logic        r_sel_q;
  logic        r_underflow_err;
  logic        r_resync_err;

  logic [10:0] w_half;
  logic        w_left;
  logic        w_right;
  logic        w_req_fall;
  logic        w_line_last;
  logic        w_flush_done;
  logic        w_frame_done;
  logic        w_uf_set;
  logic        w_rs_set;

  assign w_half       = {1'b0, h_disp[10:1]};
  assign w_left       = (pixel_xpos != 11'd0) && (pixel_xpos <= w_half);
  assign w_right      = (pixel_xpos > w_half) && (pixel_xpos <= h_disp);
  assign w_req_fall   = r_req_q & ~data_req;
  assign w_line_last  = ((r_line_cnt + 11'd1) == v_disp);
  assign w_flush_done = (r_flush_cnt == FLUSH_LAST);
  // A resync pulse takes priority over completing the frame in the same cycle.
  assign w_frame_done = (r_state == S_ACTIVE) & ~frame_start & w_req_fall & w_line_last;
  assign w_rs_set     = frame_start & (r_state != S_IDLE);

  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (frame_start) w_state_next = S_FLUSH;
      end
      S_FLUSH: begin
        if (frame_start)       w_state_next = S_FLUSH;
        else if (w_flush_done) w_state_next = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (frame_start)                    w_state_next = S_FLUSH;
        else if (w_req_fall && w_line_last) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    rd_load    = 1'b0;
    busy       = 1'b0;
    cam0_rd_en = 1'b0;
    cam1_rd_en = 1'b0;
    w_uf_set   = 1'b0;
    case (r_state)
      S_FLUSH: begin
        rd_load = 1'b1;
        busy    = 1'b1;
      end
      S_ACTIVE: begin
        busy       = 1'b1;
        cam0_rd_en = data_req & w_left & ~cam0_rd_empty;
        cam1_rd_en = data_req & w_right & ~cam1_rd_empty;
        w_uf_set   = data_req & ((w_left & cam0_rd_empty) | (w_right & cam1_rd_empty));
      end
      default: ;
    endcase
  end

  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_flush_cnt     <= 8'd0;
      r_line_cnt      <= 11'd0;
      r_frame_cnt     <= 8'd0;
      r_req_q         <= 1'b0;
      r_rd_q          <= 1'b0;
      r_sel_q         <= 1'b0;
      r_underflow_err <= 1'b0;
      r_resync_err    <= 1'b0;
    end else begin
      if (frame_start)             r_flush_cnt <= 8'd0;
      else if (r_state == S_FLUSH) r_flush_cnt <= r_flush_cnt + 8'd1;

      if (frame_start || (r_state != S_ACTIVE)) r_line_cnt <= 11'd0;
      else if (w_req_fall)                      r_line_cnt <= r_line_cnt + 11'd1;

      if (w_frame_done) r_frame_cnt <= r_frame_cnt + 8'd1;

      r_req_q <= data_req;
      r_rd_q  <= cam0_rd_en | cam1_rd_en;
      r_sel_q <= w_right;

      // Sticky flags: a new event beats a simultaneous clear.
      r_underflow_err <= w_uf_set | (r_underflow_err & ~err_clr);
      r_resync_err    <= w_rs_set | (r_resync_err & ~err_clr);
    end
  end

  assign pixel_data    = r_rd_q ? (r_sel_q ? cam1_rd_data : cam0_rd_data) : BLANK_COLOR;
  assign underflow_err = r_underflow_err;
  assign resync_err    = r_resync_err;
  assign frame_cnt     = r_frame_cnt;

endmodule

// File: tb/tb_lcd_dual_rd_sched.sv
// Directed bench for lcd_dual_rd_sched: normal frames, underflow, resync, flag clear,
// out-of-frame requests, asynchronous reset mid-line and frame counter wrap.
module tb_lcd_dual_rd_sched;

  logic        lcd_clk = 1'b0;
  logic        sys_rst_n;
  logic [10:0] h_disp;
  logic [10:0] v_disp;
  logic        frame_start;
  logic        data_req;
  logic [10:0] pixel_xpos;
  logic [15:0] cam0_rd_data;
  logic        cam0_rd_empty;
  logic [15:0] cam1_rd_data;
  logic        cam1_rd_empty;
  logic        err_clr;
  logic        rd_load;
  logic        cam0_rd_en;
  logic        cam1_rd_en;
  logic [15:0] pixel_data;
  logic        busy;
  logic        underflow_err;
  logic        resync_err;
  logic [7:0]  frame_cnt;

  int checks = 0;
  int errors = 0;

  always #5 lcd_clk = ~lcd_clk;

  lcd_dual_rd_sched #(
    .DATA_W      (16),
    .FLUSH_CYCLES(16),
    .BLANK_COLOR (16'h0000)
  ) dut (
    .lcd_clk      (lcd_clk),
    .sys_rst_n    (sys_rst_n),
    .h_disp       (h_disp),
    .v_disp       (v_disp),
    .frame_start  (frame_start),
    .data_req     (data_req),
    .pixel_xpos   (pixel_xpos),
    .cam0_rd_data (cam0_rd_data),
    .cam0_rd_empty(cam0_rd_empty),
    .cam1_rd_data (cam1_rd_data),
    .cam1_rd_empty(cam1_rd_empty),
    .err_clr      (err_clr),
    .rd_load      (rd_load),
    .cam0_rd_en   (cam0_rd_en),
    .cam1_rd_en   (cam1_rd_en),
    .pixel_data   (pixel_data),
    .busy         (busy),
    .underflow_err(underflow_err),
    .resync_err   (resync_err),
    .frame_cnt    (frame_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_frame();
    @(negedge lcd_clk);
    frame_start = 1'b1;
    data_req    = 1'b0;
    #1;
    chk("start_idle_busy", busy, 0);
  endtask

  // n flush cycles remain; data_req toggles meanwhile and must be ignored.
  task automatic flush_wait(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge lcd_clk);
      frame_start  = 1'b0;
      data_req     = (i < n - 2) ? i[0] : 1'b0;
      pixel_xpos   = 11'd2;
      cam0_rd_data = 16'hC0FF;
      cam1_rd_data = 16'hD0FF;
      #1;
      chk("flush_rd_load", rd_load, 1);
      chk("flush_en0", cam0_rd_en, 0);
      chk("flush_en1", cam1_rd_en, 0);
      chk("flush_pix", pixel_data, 16'h0000);
    end
    @(negedge lcd_clk);
    data_req = 1'b0;
    #1;
    chk("flush_end_rd_load", rd_load, 0);
    chk("flush_end_busy", busy, 1);
  endtask

  // One line of h_disp=8: xpos 0 (out of range), 1..8, 9 (out of range), then blanking.
  // uf_x: pixel whose FIFO is empty; clr: pulse err_clr on that pixel; rs_x: frame_start there.
  task automatic line(input int uf_x, input bit clr, input int rs_x);
    int  prev_x;
    bit  prev_rd;
    prev_x  = 0;
    prev_rd = 1'b0;
    for (int k = 0; k < 13; k++) begin
      int          x;
      bit          req;
      bit          oor;
      bit          exp0;
      bit          exp1;
      logic [15:0] exp_pix;
      req = (k <= 9);
      x   = req ? k : 0;
      oor = (x == 0) || (x == 9);
      @(negedge lcd_clk);
      data_req      = req;
      pixel_xpos    = 11'(x);
      cam0_rd_empty = oor || ((x == uf_x) && (x >= 1) && (x <= 4));
      cam1_rd_empty = oor || ((x == uf_x) && (x >= 5) && (x <= 8));
      err_clr       = clr && (x == uf_x) && (x != 0);
      frame_start   = (rs_x != 0) && (x == rs_x);
      cam0_rd_data  = 16'hC000 | 16'(prev_x);
      cam1_rd_data  = 16'hD000 | 16'(prev_x);
      #1;
      exp0    = req && (x >= 1) && (x <= 4) && !cam0_rd_empty;
      exp1    = req && (x >= 5) && (x <= 8) && !cam1_rd_empty;
      exp_pix = !prev_rd ? 16'h0000 :
                (prev_x > 4) ? (16'hD000 | 16'(prev_x)) : (16'hC000 | 16'(prev_x));
      chk($sformatf("line_x%0d_en0", x), cam0_rd_en, exp0);
      chk($sformatf("line_x%0d_en1", x), cam1_rd_en, exp1);
      chk($sformatf("line_after_x%0d_pix", prev_x), pixel_data, exp_pix);
      prev_x  = x;
      prev_rd = exp0 | exp1;
      if ((rs_x != 0) && (x == rs_x)) return;
    end
    err_clr       = 1'b0;
    cam0_rd_empty = 1'b0;
    cam1_rd_empty = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge lcd_clk);
    err_clr = 1'b1;
    @(negedge lcd_clk);
    err_clr = 1'b0;
    #1;
  endtask

  task automatic frame_fast();
    @(negedge lcd_clk);
    frame_start = 1'b1;
    @(negedge lcd_clk);
    frame_start = 1'b0;
    repeat (15) @(negedge lcd_clk);
    @(negedge lcd_clk);
    data_req = 1'b1; pixel_xpos = 11'd1;
    @(negedge lcd_clk);
    pixel_xpos = 11'd2;
    @(negedge lcd_clk);
    data_req = 1'b0; pixel_xpos = 11'd0;
    @(negedge lcd_clk);
  endtask

  initial begin
    sys_rst_n     = 1'b0;
    h_disp        = 11'd8;
    v_disp        = 11'd2;
    frame_start   = 1'b0;
    data_req      = 1'b0;
    pixel_xpos    = 11'd0;
    cam0_rd_data  = 16'hC0FF;
    cam0_rd_empty = 1'b0;
    cam1_rd_data  = 16'hD0FF;
    cam1_rd_empty = 1'b0;
    err_clr       = 1'b0;

    // Reset state
    repeat (2) @(negedge lcd_clk);
    #1;
    chk("rst_rd_load", rd_load, 0);
    chk("rst_busy", busy, 0);
    chk("rst_en0", cam0_rd_en, 0);
    chk("rst_en1", cam1_rd_en, 0);
    chk("rst_pix", pixel_data, 16'h0000);
    chk("rst_uf", underflow_err, 0);
    chk("rst_rs", resync_err, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    @(negedge lcd_clk);
    sys_rst_n = 1'b1;

    // Requests while idle are ignored
    for (int i = 0; i < 4; i++) begin
      @(negedge lcd_clk);
      data_req   = ~i[0];
      pixel_xpos = i[1] ? 11'd6 : 11'd2;
      #1;
      chk("idle_en0", cam0_rd_en, 0);
      chk("idle_en1", cam1_rd_en, 0);
      chk("idle_pix", pixel_data, 16'h0000);
    end

    // Normal frame
    start_frame();
    flush_wait(16);
    chk("outside_uf", underflow_err, 0);
    chk("outside_rs", resync_err, 0);
    line(0, 1'b0, 0);
    chk("f1_mid_busy", busy, 1);
    chk("f1_mid_frame_cnt", frame_cnt, 0);
    line(0, 1'b0, 0);
    chk("f1_busy", busy, 0);
    chk("f1_frame_cnt", frame_cnt, 1);
    chk("f1_uf", underflow_err, 0);

    // Underflow on cam1 at xpos 6 of line 0
    start_frame();
    flush_wait(16);
    line(6, 1'b0, 0);
    chk("uf_set", underflow_err, 1);
    line(0, 1'b0, 0);
    chk("uf_frame_cnt", frame_cnt, 2);
    pulse_clr();
    chk("uf_cleared", underflow_err, 0);

    // New underflow on cam0 collides with err_clr
    start_frame();
    flush_wait(16);
    line(3, 1'b1, 0);
    chk("collide_uf", underflow_err, 1);
    line(0, 1'b0, 0);
    chk("collide_frame_cnt", frame_cnt, 3);
    pulse_clr();
    chk("collide_cleared", underflow_err, 0);

    // Resync: frame_start at xpos 4 of line 1
    start_frame();
    flush_wait(16);
    line(0, 1'b0, 0);
    line(0, 1'b0, 4);
    @(negedge lcd_clk);
    frame_start   = 1'b0;
    err_clr       = 1'b0;
    data_req      = 1'b1;
    pixel_xpos    = 11'd5;
    cam0_rd_empty = 1'b0;
    cam1_rd_empty = 1'b0;
    cam0_rd_data  = 16'hC004;
    cam1_rd_data  = 16'hD004;
    #1;
    chk("rs_pix_last_read", pixel_data, 16'hC004);
    chk("rs_en1", cam1_rd_en, 0);
    chk("rs_rd_load", rd_load, 1);
    chk("rs_flag", resync_err, 1);
    chk("rs_frame_cnt", frame_cnt, 3);
    flush_wait(15);
    line(0, 1'b0, 0);
    chk("rs_line_restart_busy", busy, 1);
    line(0, 1'b0, 0);
    chk("rs_done_busy", busy, 0);
    chk("rs_done_frame_cnt", frame_cnt, 4);
    pulse_clr();
    chk("clr_rs", resync_err, 0);
    chk("clr_uf", underflow_err, 0);

    // Asynchronous reset at xpos 3
    start_frame();
    flush_wait(16);
    @(negedge lcd_clk);
    data_req   = 1'b1;
    pixel_xpos = 11'd1;
    #1;
    chk("prerst_en0", cam0_rd_en, 1);
    @(negedge lcd_clk);
    pixel_xpos   = 11'd2;
    cam0_rd_data = 16'hC001;
    #1;
    chk("prerst_pix", pixel_data, 16'hC001);
    @(negedge lcd_clk);
    pixel_xpos   = 11'd3;
    cam0_rd_data = 16'hC002;
    sys_rst_n    = 1'b0;
    #1;
    chk("midrst_en0", cam0_rd_en, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_rd_load", rd_load, 0);
    chk("midrst_pix", pixel_data, 16'h0000);
    chk("midrst_frame_cnt", frame_cnt, 0);
    @(negedge lcd_clk);
    sys_rst_n = 1'b1;
    data_req  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge lcd_clk);
      data_req = i[0];
      #1;
      chk("postrst_en0", cam0_rd_en, 0);
      chk("postrst_busy", busy, 0);
    end

    // Frame counter wrap with 2-pixel, 1-line frames
    h_disp = 11'd2;
    v_disp = 11'd1;
    for (int f = 0; f < 255; f++) frame_fast();
    #1;
    chk("wrap_255", frame_cnt, 255);
    frame_fast();
    #1;
    chk("wrap_0", frame_cnt, 0);
    chk("wrap_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_dual_rd_sched.md
Name: lcd_dual_rd_sched

Overview:
Per-frame read scheduler between the two camera read FIFOs and the RGB LCD timing generator. It sequences a FIFO reload at every frame start and splits each active display line: the left half is read from cam0 and the right half from cam1. It returns one merged pixel stream aligned to lcd_de. Underflow and frame-resync events are detected and reported as sticky flags.

Parameters:
DATA_W, 16, pixel width (RGB565)
FLUSH_CYCLES, 16, length in lcd_clk cycles of the rd_load pulse at frame start (valid range 1..255)
BLANK_COLOR, 16'h0000, pixel value output when no valid read occurred

Ports:
lcd_clk  in  1  pixel clock
sys_rst_n  in  1  asynchronous, active-low reset
h_disp  in  11  active pixels per line; quasi-static, even, >=2
v_disp  in  11  active lines per frame; quasi-static, >=1
frame_start  in  1  one-cycle pulse in vertical blanking, before the first active line
data_req  in  1  pixel request from the timing generator, one cycle ahead of lcd_de
pixel_xpos  in  11  1-based column during data_req (1..h_disp)
cam0_rd_data  in  DATA_W  cam0 FIFO read data, valid the cycle after cam0_rd_en
cam0_rd_empty  in  1  cam0 FIFO empty
cam1_rd_data  in  DATA_W  cam1 FIFO read data
cam1_rd_empty  in  1  cam1 FIFO empty
err_clr  in  1  clears the sticky flags
rd_load  out  1  reload/flush strobe to both read ports
cam0_rd_en  out  1  cam0 FIFO read enable
cam1_rd_en  out  1  cam1 FIFO read enable
pixel_data  out  DATA_W  merged pixel, aligned with lcd_de
busy  out  1  high in S_FLUSH and S_ACTIVE
underflow_err  out  1  sticky: a requested pixel found its FIFO empty
resync_err  out  1  sticky: frame_start arrived before the frame completed
frame_cnt  out  8  completed frames, wraps 255->0

Behaviour:
- Reset values: all outputs 0 except pixel_data=BLANK_COLOR. State S_IDLE, all counters 0.
- Split point: half = h_disp>>1.
  - Left region: 1<=pixel_xpos<=half.
  - Right region: half<pixel_xpos<=h_disp.
- FSM states:
  - S_IDLE: wait for frame_start, then go to S_FLUSH. data_req is ignored.
  - S_FLUSH: rd_load=1 for exactly FLUSH_CYCLES cycles, driven by an 8-bit counter. Then go to S_ACTIVE with line_cnt=0. data_req is ignored, no reads are issued, pixel_data=BLANK.
  - S_ACTIVE: serves requests. On each data_req falling edge (registered compare), line_cnt increments. When line_cnt reaches v_disp: go to S_IDLE and increment frame_cnt.
- frame_start in S_FLUSH or S_ACTIVE: set resync_err, restart S_FLUSH with a fresh FLUSH_CYCLES count, and clear line_cnt. frame_cnt does not increment. frame_start in S_IDLE is the normal case.
- Read enables are combinational in S_ACTIVE:
  - cam0_rd_en = data_req & left & ~cam0_rd_empty.
  - cam1_rd_en = data_req & right & ~cam1_rd_empty.
  - Both are never high together.
- Data path timing: sel_q, rd_q and req_q are registered from the current cycle.
  - Next cycle, pixel_data = sel_q ? cam1_rd_data : cam0_rd_data when rd_q=1.
  - Otherwise pixel_data = BLANK_COLOR.
  - Latency from data_req to pixel_data is one cycle, aligned with lcd_de.
- Underflow: data_req in S_ACTIVE inside a region whose FIFO is empty.
  - No read is issued, the pixel is BLANK, and underflow_err is set.
  - Scheduling continues; that pixel is not retried.
- Out-of-range pixel_xpos (0 or >h_disp) with data_req high: no read, BLANK, no error.
- err_clr clears both sticky flags. If set and clear occur in the same cycle, set wins.
- Asynchronous reset mid-frame returns to S_IDLE immediately. Reads resume only after the next frame_start plus flush.

Test Plan:
- Normal frame: h_disp=8, v_disp=2, both FIFOs non-empty, frame_start → rd_load high 16 cycles. Per line: cam0_rd_en for xpos 1..4, cam1_rd_en for xpos 5..8. pixel_data shows cam0 words then cam1 words, 1 cycle after each rd_en. frame_cnt=1, busy low afterwards.
- Underflow: cam1_rd_empty=1 during xpos 6 of line 0 → cam1_rd_en stays low for that pixel, pixel_data=16'h0000 the next cycle, underflow_err=1. The remaining pixels read normally.
- Resync: frame_start during line 1 of 2 → resync_err=1, rd_load restarts for 16 cycles, frame_cnt unchanged, line_cnt restarts from 0.
- Request outside frame: data_req toggled in S_IDLE and S_FLUSH → no rd_en, pixel_data=BLANK, no flags set.
- Flag clear collision: err_clr and a new underflow in the same cycle → underflow_err stays 1. err_clr alone on a later cycle → both flags 0.
- Reset mid-line plus wrap: assert sys_rst_n=0 during xpos 3 → all outputs reset at once. Separately, run 256 frames → frame_cnt wraps to 0.
